mem_stage: RTL

Memory-access stage of the 64-bit RISC-V pipeline, sitting directly downstream of the X/M pipeline register and upstream of the M/W register. Accepts one instruction per valid/ready handshake, issues at most one data-memory request per instruction (req/gnt, then rvalid for loads), aligns and sign/zero-extends load data, and presents a write-back result downstream. Non-memory instructions pass through with one cycle of latency. Misaligned accesses are flagged and never reach memory.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/lsu_align.sv | 52 +++++
 rtl/mem_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store funct3 encodings and access-size helpers.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    function automatic size_t f3_size(input logic [2:0] funct3);
        return size_t'(funct3[1:0]);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
        case (f3_size(funct3))
            SZ_H:    return addr_lo[0];
            SZ_W:    return |addr_lo[1:0];
            SZ_D:    return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: request side (misalign, byte enables, store shift)
// and response side (load extract and sign/zero extension).
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  req_funct3,
    input  logic [2:0]  req_addr_lo,
    input  logic [63:0] store_data,
    output logic        misalign,
    output logic [7:0]  be,
    output logic [63:0] wdata,
    input  logic [2:0]  rsp_funct3,
    input  logic [2:0]  rsp_addr_lo,
    input  logic [63:0] rdata,
    output logic [63:0] load_data
);

    logic [7:0]  size_mask;
    logic [63:0] rdata_shifted;
    logic        zext;

    assign misalign = is_misaligned(req_funct3, req_addr_lo);

    always_comb begin
        size_mask = 8'h01;
        case (f3_size(req_funct3))
            SZ_B: size_mask = 8'h01;
            SZ_H: size_mask = 8'h03;
            SZ_W: size_mask = 8'h0F;
            SZ_D: size_mask = 8'hFF;
            default: size_mask = 8'h01;
        endcase
    end

    assign be    = size_mask << req_addr_lo;
    assign wdata = store_data << {req_addr_lo, 3'b000};

    assign rdata_shifted = rdata >> {rsp_addr_lo, 3'b000};
    assign zext          = rsp_funct3[2];

    always_comb begin
        load_data = rdata_shifted;
        case (f3_size(rsp_funct3))
            SZ_B: load_data = {{56{~zext & rdata_shifted[7]}},  rdata_shifted[7:0]};
            SZ_H: load_data = {{48{~zext & rdata_shifted[15]}}, rdata_shifted[15:0]};
            SZ_W: load_data = {{32{~zext & rdata_shifted[31]}}, rdata_shifted[31:0]};
            SZ_D: load_data = rdata_shifted;
            default: load_data = rdata_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one data-memory transaction per instruction,
// load alignment/extension, and a valid/ready write-back result.
//
// state | meaning
// IDLE  | empty, accepting
// REQ   | dmem_req_o held until gnt
// WAIT  | load granted, waiting for rvalid
// DONE  | result presented downstream
// DRAIN | flushed load, discarding its rvalid
module mem_stage
    import riscv_pkg::*;
#(
    parameter bit ClearDataOnReset = 1'b0,
    parameter int RdWidth          = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [63:0]        result_i,
    input  logic [63:0]        store_data_i,
    input  logic [2:0]         funct3_i,
    input  logic [RdWidth-1:0] rd_i,
    input  logic               RegWrite_i,
    input  logic               MemWrite_i,
    input  logic               MemRead_i,
    output logic               dmem_req_o,
    input  logic               dmem_gnt_i,
    output logic               dmem_we_o,
    output logic [63:0]        dmem_addr_o,
    output logic [7:0]         dmem_be_o,
    output logic [63:0]        dmem_wdata_o,
    input  logic               dmem_rvalid_i,
    input  logic [63:0]        dmem_rdata_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [63:0]        wb_data_o,
    output logic [RdWidth-1:0] rd_o,
    output logic               RegWrite_o,
    output logic               misalign_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [63:0]        addr_q;
    logic [2:0]         funct3_q;
    logic               we_q;
    logic [7:0]         be_q;
    logic [63:0]        wdata_q;
    logic [63:0]        wb_data_q;
    logic [RdWidth-1:0] rd_q;
    logic               regwrite_q;
    logic               misalign_q;

    logic               in_mem;
    logic               in_misalign_raw;
    logic               in_misalign;
    logic [7:0]         in_be;
    logic [63:0]        in_wdata;
    logic [63:0]        load_data;
    logic               capture;
    logic               load_latch;
    state_t             capture_state;

    lsu_align u_lsu_align (
        .req_funct3  (funct3_i),
        .req_addr_lo (result_i[2:0]),
        .store_data  (store_data_i),
        .misalign    (in_misalign_raw),
        .be          (in_be),
        .wdata       (in_wdata),
        .rsp_funct3  (funct3_q),
        .rsp_addr_lo (addr_q[2:0]),
        .rdata       (dmem_rdata_i),
        .load_data   (load_data)
    );

    assign in_mem        = MemRead_i | MemWrite_i;
    assign in_misalign   = in_mem & in_misalign_raw;
    assign capture_state = (in_mem && !in_misalign) ? REQ : DONE;

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        ready_o    = 1'b0;
        load_latch = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (valid_i) begin
                    capture = 1'b1;
                    state_d = capture_state;
                end
            end
            REQ: begin
                // A granted store has already reached memory, so a flush only drops it here.
                if (dmem_gnt_i) begin
                    if (flush_i) state_d = we_q ? IDLE : DRAIN;
                    else         state_d = we_q ? DONE : WAIT;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    load_latch = ~flush_i;
                    state_d    = flush_i ? IDLE : DONE;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                ready_o = ready_i;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (ready_i) begin
                    if (valid_i) begin
                        capture = 1'b1;
                        state_d = capture_state;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (dmem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (capture) begin
            addr_q   <= result_i;
            funct3_q <= funct3_i;
            we_q     <= MemWrite_i;
            be_q     <= in_be;
            wdata_q  <= in_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            regwrite_q <= 1'b0;
            misalign_q <= 1'b0;
            if (ClearDataOnReset) begin
                wb_data_q <= '0;
                rd_q      <= '0;
            end
        end else if (capture) begin
            wb_data_q  <= result_i;
            rd_q       <= rd_i;
            regwrite_q <= RegWrite_i & ~in_misalign;
            misalign_q <= in_misalign;
        end else if (load_latch) begin
            wb_data_q <= load_data;
        end
    end

    assign dmem_req_o   = (state_q == REQ);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = {addr_q[63:3], 3'b000};
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;

    assign valid_o    = (state_q == DONE);
    assign wb_data_o  = wb_data_q;
    assign rd_o       = rd_q;
    assign RegWrite_o = regwrite_q;
    assign misalign_o = misalign_q;

endmodule
